// File: rtl/branch_steer.sv
// Dataflow steer node: pairs condition and data tokens through per-stream
// FIFOs and routes each data token to the TRUE or FALSE output port.

module steer_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         en,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         nempty,
   output logic         ovf_evt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rp;
   logic [AW-1:0] wp;
   logic [CW-1:0] cnt;
   logic          full;
   logic          wr;
   logic          rd;

   assign full    = (cnt == FULL);
   assign nempty  = (cnt != '0);
   assign rd      = en & pop & nempty;
   // A full FIFO still accepts a token when its head leaves this cycle.
   assign wr      = en & push & (~full | rd);
   assign ovf_evt = en & push & full & ~rd;
   assign rdata   = mem[rp];

   always_ff @(posedge CLK) begin
      if (wr) begin
         mem[wp] <= wdata;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else begin
         if (wr) begin
            wp <= wp + AW'(1);
         end
         if (rd) begin
            rp <= rp + AW'(1);
         end
         unique case ({wr, rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

module branch_steer #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         EN,
   input  logic         RC_IN,
   input  logic         C_IN,
   input  logic         RD_IN,
   input  logic [N-1:0] D_IN,
   output logic         RT_OUT,
   output logic [N-1:0] DT_OUT,
   output logic         RF_OUT,
   output logic [N-1:0] DF_OUT,
   output logic         OVF
);

   logic         c_ne;
   logic         d_ne;
   logic         c_head;
   logic [N-1:0] d_head;
   logic         c_ovf;
   logic         d_ovf;
   logic         fire;
   logic         cond;
   logic [N-1:0] data;
   logic         push_c;
   logic         push_d;
   logic         pop_c;
   logic         pop_d;

   assign fire = (c_ne | RC_IN) & (d_ne | RD_IN);
   assign cond = c_ne ? c_head : C_IN;
   assign data = d_ne ? d_head : D_IN;

   // An input token consumed straight from the port is never enqueued.
   assign pop_c  = fire & c_ne;
   assign pop_d  = fire & d_ne;
   assign push_c = RC_IN & ~(fire & ~c_ne);
   assign push_d = RD_IN & ~(fire & ~d_ne);

   steer_fifo #(
      .W     (1),
      .DEPTH (DEPTH)
   ) u_cfifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .en      (EN),
      .push    (push_c),
      .pop     (pop_c),
      .wdata   (C_IN),
      .rdata   (c_head),
      .nempty  (c_ne),
      .ovf_evt (c_ovf)
   );

   steer_fifo #(
      .W     (N),
      .DEPTH (DEPTH)
   ) u_dfifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .en      (EN),
      .push    (push_d),
      .pop     (pop_d),
      .wdata   (D_IN),
      .rdata   (d_head),
      .nempty  (d_ne),
      .ovf_evt (d_ovf)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         RT_OUT <= 1'b0;
         RF_OUT <= 1'b0;
         DT_OUT <= '0;
         DF_OUT <= '0;
         OVF    <= 1'b0;
      end else if (EN) begin
         RT_OUT <= fire & cond;
         RF_OUT <= fire & ~cond;
         if (fire & cond) begin
            DT_OUT <= data;
         end
         if (fire & ~cond) begin
            DF_OUT <= data;
         end
         if (c_ovf | d_ovf) begin
            OVF <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_steer.sv
// Directed bench for branch_steer: alignment, skew, overflow, full
// push/pop, enable freeze and asynchronous reset.

module tb_branch_steer;

   logic        CLK;
   logic        RST_N;
   logic        EN;
   logic        RC_IN;
   logic        C_IN;
   logic        RD_IN;
   logic [15:0] D_IN;
   logic        RT_OUT;
   logic [15:0] DT_OUT;
   logic        RF_OUT;
   logic [15:0] DF_OUT;
   logic        OVF;

   int compared;
   int mismatched;

   branch_steer #(
      .N     (16),
      .DEPTH (4)
   ) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .EN     (EN),
      .RC_IN  (RC_IN),
      .C_IN   (C_IN),
      .RD_IN  (RD_IN),
      .D_IN   (D_IN),
      .RT_OUT (RT_OUT),
      .DT_OUT (DT_OUT),
      .RF_OUT (RF_OUT),
      .DF_OUT (DF_OUT),
      .OVF    (OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drive(input logic rc, input logic c, input logic rd,
                        input logic [15:0] d);
      RC_IN = rc;
      C_IN  = c;
      RD_IN = rd;
      D_IN  = d;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      EN = 1'b1;
      step();
      RST_N = 1'b1;
      step();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      RST_N      = 1'b1;
      EN         = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      @(negedge CLK);
      do_reset();
      chk("rst_rt", 32'(RT_OUT), 32'h0);
      chk("rst_rf", 32'(RF_OUT), 32'h0);
      chk("rst_dt", 32'(DT_OUT), 32'h0);
      chk("rst_df", 32'(DF_OUT), 32'h0);
      chk("rst_ovf", 32'(OVF), 32'h0);

      // T1 aligned tokens
      drive(1'b1, 1'b1, 1'b1, 16'h1234);
      step();
      chk("t1_rt", 32'(RT_OUT), 32'h1);
      chk("t1_dt", 32'(DT_OUT), 32'h1234);
      chk("t1_rf", 32'(RF_OUT), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("t1_rt_low", 32'(RT_OUT), 32'h0);
      chk("t1_dt_hold", 32'(DT_OUT), 32'h1234);

      // T2 skewed streams
      drive(1'b0, 1'b0, 1'b1, 16'hAAAA);
      step();
      chk("t2_q0", 32'({RT_OUT, RF_OUT}), 32'h0);
      drive(1'b0, 1'b0, 1'b1, 16'hBBBB);
      step();
      chk("t2_q1", 32'({RT_OUT, RF_OUT}), 32'h0);
      drive(1'b0, 1'b0, 1'b1, 16'hCCCC);
      step();
      chk("t2_q2", 32'({RT_OUT, RF_OUT}), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      step();
      step();
      chk("t2_gap", 32'({RT_OUT, RF_OUT}), 32'h0);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      step();
      chk("t2_a_r", 32'({RT_OUT, RF_OUT}), 32'h1);
      chk("t2_a_d", 32'(DF_OUT), 32'hAAAA);
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      step();
      chk("t2_b_r", 32'({RT_OUT, RF_OUT}), 32'h2);
      chk("t2_b_d", 32'(DT_OUT), 32'hBBBB);
      chk("t2_b_dfh", 32'(DF_OUT), 32'hAAAA);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      step();
      chk("t2_c_r", 32'({RT_OUT, RF_OUT}), 32'h1);
      chk("t2_c_d", 32'(DF_OUT), 32'hCCCC);
      chk("t2_c_dth", 32'(DT_OUT), 32'hBBBB);
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("t2_idle", 32'({RT_OUT, RF_OUT}), 32'h0);

      // T3 overflow on the data FIFO
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 16'(i));
         step();
         if (i == 4) chk("t3_ovf_pre", 32'(OVF), 32'h0);
      end
      chk("t3_ovf_set", 32'(OVF), 32'h1);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b1, 1'b0, 16'h0);
         step();
         chk($sformatf("t3_rt%0d", i), 32'(RT_OUT), 32'h1);
         chk($sformatf("t3_dt%0d", i), 32'(DT_OUT), 32'(i));
      end
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      step();
      chk("t3_no5", 32'({RT_OUT, RF_OUT}), 32'h0);
      chk("t3_dt_hold", 32'(DT_OUT), 32'h4);
      chk("t3_ovf_stick", 32'(OVF), 32'h1);

      // T4 full FIFO with push and pop together
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 16'h0011);
      step();
      drive(1'b0, 1'b0, 1'b1, 16'h0022);
      step();
      drive(1'b0, 1'b0, 1'b1, 16'h0033);
      step();
      drive(1'b0, 1'b0, 1'b1, 16'h0044);
      step();
      drive(1'b1, 1'b0, 1'b1, 16'h0009);
      step();
      chk("t4_rf", 32'({RT_OUT, RF_OUT}), 32'h1);
      chk("t4_df", 32'(DF_OUT), 32'h0011);
      chk("t4_ovf", 32'(OVF), 32'h0);
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      step();
      chk("t4_d22", 32'(DT_OUT), 32'h0022);
      step();
      chk("t4_d33", 32'(DT_OUT), 32'h0033);
      step();
      chk("t4_d44", 32'(DT_OUT), 32'h0044);
      step();
      chk("t4_d09", 32'(DT_OUT), 32'h0009);
      chk("t4_rt9", 32'(RT_OUT), 32'h1);
      step();
      chk("t4_empty", 32'({RT_OUT, RF_OUT}), 32'h0);
      chk("t4_ovf_end", 32'(OVF), 32'h0);

      // T5 enable freeze
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 16'h0055);
      step();
      EN = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("t5_frz%0d", i), 32'({RT_OUT, RF_OUT}), 32'h0);
      end
      chk("t5_dt_frz", 32'(DT_OUT), 32'h0);
      EN = 1'b1;
      step();
      chk("t5_rt", 32'(RT_OUT), 32'h1);
      chk("t5_dt", 32'(DT_OUT), 32'h0055);
      EN = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("t5_hold_rt", 32'(RT_OUT), 32'h1);
      EN = 1'b1;
      step();
      chk("t5_rt_low", 32'(RT_OUT), 32'h0);
      step();
      chk("t5_no_extra", 32'({RT_OUT, RF_OUT}), 32'h0);

      // T6 asynchronous reset mid-operation
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 16'h0066);
      step();
      drive(1'b0, 1'b0, 1'b1, 16'h0077);
      step();
      drive(1'b0, 1'b0, 1'b1, 16'h0088);
      step();
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      step();
      chk("t6_rt_pre", 32'(RT_OUT), 32'h1);
      chk("t6_dt_pre", 32'(DT_OUT), 32'h0066);
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      #2;
      RST_N = 1'b0;
      #1;
      chk("t6_rt_async", 32'(RT_OUT), 32'h0);
      chk("t6_dt_async", 32'(DT_OUT), 32'h0);
      chk("t6_rf_async", 32'({RF_OUT, DF_OUT}), 32'h0);
      chk("t6_ovf_async", 32'(OVF), 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      step();
      chk("t6_lone_c", 32'({RT_OUT, RF_OUT}), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("t6_lone_c2", 32'({RT_OUT, RF_OUT}), 32'h0);
      chk("t6_dt_zero", 32'(DT_OUT), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
